ifu: RTL and testbench

- Instruction fetch unit that sits directly upstream of the control decoder.
- Holds the PC and fetches one instruction per step through a req/ready handshake to instruction memory.
- Presents the latched instruction, opcode and funct to the decoder, and computes the next PC from the decoder's pc_op once downstream signals advance.
- Multi-cycle style: one instruction is in flight at a time.

---
 rtl/ifu_pkg.sv | 37 +++
 rtl/ifu_npc.sv | 43 ++++
 rtl/ifu.sv | 113 +++++++++++
 tb/tb_ifu.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared fetch-unit definitions: next-PC select codes, instruction field positions,
// default reset PC and FSM state encodings. S_ERR exists only with IFU_ALIGN_CHECK_EN.
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam logic [1:0] PC_OP_SEQ    = 2'b00;
    localparam logic [1:0] PC_OP_BRANCH = 2'b01;
    localparam logic [1:0] PC_OP_JUMP   = 2'b10;
    localparam logic [1:0] PC_OP_JR     = 2'b11;

    localparam int OPCODE_MSB   = 31;
    localparam int OPCODE_LSB   = 26;
    localparam int FUNCT_MSB    = 5;
    localparam int FUNCT_LSB    = 0;
    localparam int IMM16_MSB    = 15;
    localparam int IMM16_LSB    = 0;
    localparam int TARGET26_MSB = 25;
    localparam int TARGET26_LSB = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
`ifdef IFU_ALIGN_CHECK_EN
        S_VALID = 2'd2,
        S_ERR   = 2'd3
`else
        S_VALID = 2'd2
`endif
    } ifu_state_t;

    // Branch displacement is a signed word count, so it becomes a byte offset here.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_npc.sv
// Combinational next-PC calculator for the fetch unit; all arithmetic wraps modulo 2^32.
module ifu_npc
    import ifu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [1:0]  pc_op,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    output logic [31:0] next_pc
);

    logic [31:0] pc_seq;
    logic        unused_opcode_bits;

    assign pc_seq             = pc + 32'd4;
    assign unused_opcode_bits = ^instr[OPCODE_MSB:OPCODE_LSB];

    always_comb begin
        next_pc = pc_seq;
        case (pc_op)
            PC_OP_SEQ: begin
                next_pc = pc_seq;
            end
            PC_OP_BRANCH: begin
                if (branch_taken) begin
                    next_pc = pc_seq + branch_offset(instr[IMM16_MSB:IMM16_LSB]);
                end
            end
            // Jump keeps the region bits of the delay-slot-free sequential PC.
            PC_OP_JUMP: begin
                next_pc = {pc_seq[31:28], instr[TARGET26_MSB:TARGET26_LSB], 2'b00};
            end
            PC_OP_JR: begin
                next_pc = jr_target;
            end
            default: begin
                next_pc = pc_seq;
            end
        endcase
    end

endmodule

// File: rtl/ifu.sv
// Multi-cycle instruction fetch unit: PC, instruction register and fetch FSM.
// Define IFU_ALIGN_CHECK_EN to trap misaligned next-PC values via fetch_err.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  pc_op,
    input  logic        branch_taken,
    input  logic [31:0] jr_target,
    input  logic        advance,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
`ifdef IFU_ALIGN_CHECK_EN
    output logic        fetch_err,
`endif
    output logic        instr_valid
);

    ifu_state_t  state;
    logic [31:0] next_pc;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;
    assign opcode    = instr[OPCODE_MSB:OPCODE_LSB];
    assign funct     = instr[FUNCT_MSB:FUNCT_LSB];

    ifu_npc u_npc (
        .pc           (pc),
        .instr        (instr),
        .pc_op        (pc_op),
        .branch_taken (branch_taken),
        .jr_target    (jr_target),
        .next_pc      (next_pc)
    );

`ifndef IFU_ALIGN_CHECK_EN
    logic unused_npc_low_bits;
    assign unused_npc_low_bits = ^next_pc[1:0];
`endif

    // imem_req and instr_valid are registered alongside the state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
            fetch_err   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_req && imem_ready) begin
                        instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (advance) begin
`ifdef IFU_ALIGN_CHECK_EN
                        if (next_pc[1:0] != 2'b00) begin
                            fetch_err   <= 1'b1;
                            instr_valid <= 1'b0;
                            imem_req    <= 1'b0;
                            state       <= S_ERR;
                        end else begin
                            pc          <= next_pc;
                            instr_valid <= 1'b0;
                            imem_req    <= 1'b1;
                            state       <= S_FETCH;
                        end
`else
                        pc          <= {next_pc[31:2], 2'b00};
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= S_FETCH;
`endif
                    end
                end
`ifdef IFU_ALIGN_CHECK_EN
                S_ERR: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
`endif
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus randomized fetch/advance traffic
// compared against a behavioural next-PC model.
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [1:0]  pc_op = 2'b00;
    logic        branch_taken = 1'b0;
    logic [31:0] jr_target = 32'h0;
    logic        advance = 1'b0;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_valid;
`ifdef IFU_ALIGN_CHECK_EN
    logic        fetch_err;
`endif

    int total = 0;
    int bad = 0;

    logic [31:0] model_pc;
    logic [31:0] model_instr;

    ifu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .pc_op        (pc_op),
        .branch_taken (branch_taken),
        .jr_target    (jr_target),
        .advance      (advance),
        .instr        (instr),
        .opcode       (opcode),
        .funct        (funct),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
`ifdef IFU_ALIGN_CHECK_EN
        .fetch_err    (fetch_err),
`endif
        .instr_valid  (instr_valid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference next PC from the architectural rules, using signed integer offsets.
    function automatic logic [31:0] refNextPc(input logic [31:0] cur_pc, input logic [31:0] word,
                                              input logic [1:0] op, input logic taken,
                                              input logic [31:0] jrt);
        logic [31:0] result;
        int          offset;
        offset = int'($signed(word[15:0])) * 4;
        case (op)
            2'd0:    result = cur_pc + 32'd4;
            2'd1:    result = taken ? (cur_pc + 32'd4 + 32'(offset)) : (cur_pc + 32'd4);
            2'd2:    result = ((cur_pc + 32'd4) & 32'hF000_0000) | ({6'b0, word[25:0]} << 2);
            default: result = jrt;
        endcase
`ifndef IFU_ALIGN_CHECK_EN
        result[1:0] = 2'b00;
`endif
        return result;
    endfunction

    // Runs one fetch from S_FETCH: optional wait states, optional ignored advance pulses.
    task automatic fetchInstr(input logic [31:0] word, input int waits, input bit poke_advance);
        checkOutput("fetch_req", 32'(imem_req), 1);
        checkOutput("fetch_addr", imem_addr, model_pc);
        checkOutput("fetch_valid_low", 32'(instr_valid), 0);
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            advance    = poke_advance;
            pc_op      = 2'($urandom);
            jr_target  = $urandom;
            tick();
            checkOutput("wait_req_hold", 32'(imem_req), 1);
            checkOutput("wait_addr_hold", imem_addr, model_pc);
            checkOutput("wait_valid_low", 32'(instr_valid), 0);
        end
        advance    = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = word;
        tick();
        imem_ready  = 1'b0;
        imem_rdata  = $urandom;
        model_instr = word;
        checkOutput("valid_high", 32'(instr_valid), 1);
        checkOutput("req_dropped", 32'(imem_req), 0);
        checkOutput("instr", instr, word);
        checkOutput("opcode", 32'(opcode), 32'(word[31:26]));
        checkOutput("funct", 32'(funct), 32'(word[5:0]));
        checkOutput("pc_hold", pc, model_pc);
        checkOutput("pc_plus4", pc_plus4, model_pc + 32'd4);
        // Stray ready pulses while no request is out must not disturb the instruction.
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            tick();
            checkOutput("valid_idle_instr", instr, model_instr);
            checkOutput("valid_idle_flag", 32'(instr_valid), 1);
        end
        imem_ready = 1'b0;
    endtask

    // Pulses advance from S_VALID and checks the next fetch address against the model.
    task automatic applyStimulus(input logic [1:0] op, input logic taken, input logic [31:0] jrt);
        logic [31:0] exp;
        exp          = refNextPc(model_pc, model_instr, op, taken, jrt);
        pc_op        = op;
        branch_taken = taken;
        jr_target    = jrt;
        advance      = 1'b1;
        tick();
        advance      = 1'b0;
        pc_op        = 2'($urandom);
        branch_taken = 1'($urandom);
        jr_target    = $urandom;
        model_pc     = exp;
        checkOutput("npc_addr", imem_addr, exp);
        checkOutput("npc_req", 32'(imem_req), 1);
        checkOutput("npc_valid_drop", 32'(instr_valid), 0);
    endtask

    initial begin
        logic [31:0] word;
        logic [31:0] jrt;

        repeat (2) tick();
        checkOutput("rst_req", 32'(imem_req), 0);
        checkOutput("rst_valid", 32'(instr_valid), 0);
        checkOutput("rst_pc", pc, 32'h0000_3000);
        checkOutput("rst_instr", instr, 32'h0);
`ifdef IFU_ALIGN_CHECK_EN
        checkOutput("rst_fetch_err", 32'(fetch_err), 0);
`endif
        rst_n = 1'b1;
        tick();
        model_pc = 32'h0000_3000;
        checkOutput("first_addr", imem_addr, 32'h0000_3000);
        fetchInstr(32'h2408_0005, 0, 1'b0);
        checkOutput("first_opcode", 32'(opcode), 32'h09);

        applyStimulus(2'd0, 1'b0, 32'h0);
        checkOutput("seq_addr", imem_addr, 32'h0000_3004);
        fetchInstr($urandom, 0, 1'b0);
        checkOutput("seq_pc_plus4", pc_plus4, 32'h0000_3008);

        applyStimulus(2'd3, 1'b0, 32'hFFFF_FFFC);
        fetchInstr($urandom, 0, 1'b0);
        applyStimulus(2'd0, 1'b0, 32'h0);
        checkOutput("wrap_addr", imem_addr, 32'h0);

        fetchInstr($urandom, 0, 1'b0);
        applyStimulus(2'd3, 1'b0, 32'h0000_3010);
        fetchInstr(32'h1234_FFFE, 0, 1'b0);
        applyStimulus(2'd1, 1'b1, 32'h0);
        checkOutput("br_taken_addr", imem_addr, 32'h0000_300C);
        fetchInstr($urandom, 0, 1'b0);
        applyStimulus(2'd3, 1'b0, 32'h0000_3010);
        fetchInstr(32'h1234_FFFE, 0, 1'b0);
        applyStimulus(2'd1, 1'b0, 32'h0);
        checkOutput("br_not_taken_addr", imem_addr, 32'h0000_3014);

        fetchInstr($urandom, 0, 1'b0);
        applyStimulus(2'd3, 1'b0, 32'h0000_3000);
        fetchInstr(32'h0800_0C10, 0, 1'b0);
        applyStimulus(2'd2, 1'b0, 32'h0);
        checkOutput("jump_addr", imem_addr, 32'h0000_3040);
        fetchInstr($urandom, 0, 1'b0);
        applyStimulus(2'd3, 1'b0, 32'h0000_3100);
        checkOutput("jr_addr", imem_addr, 32'h0000_3100);

        fetchInstr($urandom, 3, 1'b1);

        for (int n = 0; n < 80; n++) begin
            jrt = $urandom;
`ifdef IFU_ALIGN_CHECK_EN
            jrt[1:0] = 2'b00;
`endif
            applyStimulus(2'($urandom), 1'($urandom), jrt);
            word = $urandom;
            fetchInstr(word, int'($urandom_range(0, 3)), 1'($urandom));
        end

        applyStimulus(2'd0, 1'b0, 32'h0);
        imem_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_req", 32'(imem_req), 0);
        checkOutput("midrst_pc", pc, 32'h0000_3000);
        checkOutput("midrst_valid", 32'(instr_valid), 0);
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("late_ready_instr", instr, 32'h0);
        checkOutput("late_ready_valid", 32'(instr_valid), 0);
        checkOutput("post_rst_req", 32'(imem_req), 1);
        imem_ready = 1'b0;
        model_pc = 32'h0000_3000;
        fetchInstr($urandom, 1, 1'b0);

        pc_op     = 2'd3;
        jr_target = 32'h0000_3102;
        advance   = 1'b1;
        tick();
        advance   = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        checkOutput("misalign_err", 32'(fetch_err), 1);
        checkOutput("misalign_req", 32'(imem_req), 0);
        checkOutput("misalign_pc", pc, 32'h0000_3000);
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'($urandom);
            advance    = 1'($urandom);
            tick();
            checkOutput("err_hold_req", 32'(imem_req), 0);
            checkOutput("err_hold_valid", 32'(instr_valid), 0);
            checkOutput("err_sticky", 32'(fetch_err), 1);
        end
        advance    = 1'b0;
        imem_ready = 1'b0;
`else
        checkOutput("misalign_forced_addr", imem_addr, 32'h0000_3100);
        checkOutput("misalign_req", 32'(imem_req), 1);
        model_pc = 32'h0000_3100;
        fetchInstr($urandom, 0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
